gpcfg_ahb_if: RTL and testbench

//  AHB-Lite slave front-end of the gpcfg register bank, directly upstream of the read-data OR-mux.

---
 rtl/gpcfg_pkg.sv | 21 ++
 rtl/gpcfg_addr_chk.sv | 27 ++
 rtl/gpcfg_ahb_if.sv | 99 +++++++++
 tb/tb_gpcfg_ahb_if.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gpcfg_pkg.sv
// rtl/gpcfg_pkg.sv - shared AHB-Lite encodings and FSM state codes for the gpcfg front-end
package gpcfg_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_DONE = 3'd3;
  localparam logic [2:0] ST_ERR1    = 3'd4;
  localparam logic [2:0] ST_ERR2    = 3'd5;

endpackage

// File: rtl/gpcfg_addr_chk.sv
// rtl/gpcfg_addr_chk.sv - combinational word-index and legality decode of an AHB address phase
module gpcfg_addr_chk
  import gpcfg_pkg::*;
#(
  parameter int          NUM_REGS  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         IDX_W     = $clog2(NUM_REGS)
) (
  input  logic [31:0]      haddr,
  input  logic [2:0]       hsize,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  localparam int UB = IDX_W + 2;

  logic [31:0] idx_ext;

  always_comb begin
    idx     = haddr[UB-1:2];
    idx_ext = 32'(idx);
    // Bits above the index field must match the bank's base; non-power-of-two banks also bound idx.
    legal   = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00) &&
              (idx_ext < 32'(NUM_REGS)) && (haddr[31:UB] == BASE_ADDR[31:UB]);
  end

endmodule

// File: rtl/gpcfg_ahb_if.sv
// rtl/gpcfg_ahb_if.sv - AHB-Lite slave front-end of the gpcfg register bank
// Optional ERROR response path for illegal accesses built when GPCFG_ERR_RESP_EN is defined.
module gpcfg_ahb_if
  import gpcfg_pkg::*;
#(
  parameter int          NUM_REGS  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         IDX_W     = $clog2(NUM_REGS)
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             hsel,
  input  logic [31:0]      haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [31:0]      hwdata,
  input  logic             hready,
  output logic             hreadyout,
  output logic             hresp,
  output logic [IDX_W-1:0] reg_idx,
  output logic             wr_en,
  output logic [31:0]      wr_data,
  output logic             rd_en,
  output logic             valid_rd
);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             legal_q, legal_d;
  logic [IDX_W-1:0] chk_idx;
  logic             chk_legal;
  logic             accept;

  gpcfg_addr_chk #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_chk (
    .haddr (haddr),
    .hsize (hsize),
    .idx   (chk_idx),
    .legal (chk_legal)
  );

  always_comb begin
    hreadyout = !((state_q == ST_RD_WAIT) || (state_q == ST_ERR1));
`ifdef GPCFG_ERR_RESP_EN
    hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
    hresp     = HRESP_OKAY;
`endif
    // legal_q only gates anything in the OKAY-only build; otherwise illegal never reaches WR/RD_WAIT.
    wr_en     = (state_q == ST_WR) && legal_q;
    rd_en     = (state_q == ST_RD_WAIT) && legal_q;
    valid_rd  = rd_en;
    wr_data   = wr_en ? hwdata : 32'h0;
    reg_idx   = idx_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    legal_d = legal_q;
    accept  = hsel && hready && hreadyout &&
              ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    case (state_q)
      ST_RD_WAIT: state_d = ST_RD_DONE;
`ifdef GPCFG_ERR_RESP_EN
      ST_ERR1:    state_d = ST_ERR2;
`endif
      default: begin
        if (accept) begin
          idx_d   = chk_idx;
          legal_d = chk_legal;
`ifdef GPCFG_ERR_RESP_EN
          if (!chk_legal) state_d = ST_ERR1;
          else
`endif
          state_d = hwrite ? ST_WR : ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      legal_q <= legal_d;
    end
  end

endmodule

// File: tb/tb_gpcfg_ahb_if.sv
// tb/tb_gpcfg_ahb_if.sv - table-driven bench for gpcfg_ahb_if with a registered read-mux model
module tb_gpcfg_ahb_if;

  localparam int NUM_REGS = 1024;
  localparam int IDX_W    = 10;
  localparam int OW       = 5 + IDX_W + 64;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic             hclk = 1'b0;
  logic             hreset;
  logic             hsel;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [31:0]      hwdata;
  logic             hready;
  logic             hreadyout;
  logic             hresp;
  logic [IDX_W-1:0] reg_idx;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             rd_en;
  logic             valid_rd;

  logic [31:0] mem [0:NUM_REGS-1];
  logic [31:0] hrdata;

  int checks = 0;
  int passes = 0;

  gpcfg_ahb_if #(.NUM_REGS(NUM_REGS), .BASE_ADDR(32'h0)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .reg_idx   (reg_idx),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .valid_rd  (valid_rd)
  );

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  // Register array plus registered OR-mux: only the strobed register reaches hrdata.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hrdata <= 32'h0;
    end else begin
      if (wr_en) mem[reg_idx] <= wr_data;
      hrdata <= valid_rd ? mem[reg_idx] : 32'h0;
    end
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rdy;
    logic        e_resp;
    logic        e_wr;
    logic        e_rd;
    logic [9:0]  e_idx;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic logic [OW-1:0] obs();
    return {hreadyout, hresp, wr_en, rd_en, valid_rd, reg_idx, wr_data, hrdata};
  endfunction

  function automatic logic [OW-1:0] mk(logic rdy, logic resp, logic wr, logic rd,
                                       logic [9:0] idx, logic [31:0] wd, logic [31:0] rdat);
    return {rdy, resp, wr, rd, rd, idx, wd, rdat};
  endfunction

  task automatic check(string name, logic [OW-1:0] exp, logic [OW-1:0] mask);
    logic [OW-1:0] act;
    act = obs();
    checks++;
    if ((act & mask) === (exp & mask)) passes++;
    else $display("FAIL %s: got rdy/resp/wr/rd/vrd/idx/wdata/rdata=%h required %h (mask %h)",
                  name, act, exp, mask);
  endtask

  task automatic drive(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                       logic [31:0] a, logic [31:0] wd);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  localparam logic [OW-1:0] ALL   = '1;
  // Ignore reg_idx and wr_data where the captured index of an illegal access is irrelevant.
  localparam logic [OW-1:0] NOIDX = {5'b11111, {IDX_W{1'b0}}, 32'h0, 32'hFFFF_FFFF};

  // Illegal access: drive one address phase, then follow the two response cycles.
  task automatic illegal(string name, logic wr, logic [2:0] sz, logic [31:0] a);
    drive(1'b1, T_NSEQ, wr, sz, a, 32'h0);
    #3 check({name, "_accept"}, mk(1, 0, 0, 0, 0, 0, 0), NOIDX);
    step();
    drive(1'b1, T_IDLE, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFFF);
`ifdef GPCFG_ERR_RESP_EN
    #3 check({name, "_err1"}, mk(0, 1, 0, 0, 0, 0, 0), NOIDX);
    step();
    #3 check({name, "_err2"}, mk(1, 1, 0, 0, 0, 0, 0), NOIDX);
`else
    if (wr) begin
      #3 check({name, "_wr_drop"}, mk(1, 0, 0, 0, 0, 0, 0), NOIDX);
    end else begin
      #3 check({name, "_rd_wait"}, mk(0, 0, 0, 0, 0, 0, 0), NOIDX);
      step();
      #3 check({name, "_rd_zero"}, mk(1, 0, 0, 0, 0, 0, 0), NOIDX);
    end
`endif
    step();
    #3 check({name, "_idle"}, mk(1, 0, 0, 0, 0, 0, 0), NOIDX);
    step();
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, T_NSEQ, 1, 3'b010, 32'h10, 32'h0,         1, 0, 0, 0, 10'd0,  32'h0,         32'h0};
    tbl[1]  = '{1, T_IDLE, 0, 3'b010, 32'h0,  32'hDEADBEEF,  1, 0, 1, 0, 10'd4,  32'hDEADBEEF,  32'h0};
    tbl[2]  = '{1, T_NSEQ, 0, 3'b010, 32'h10, 32'h0,         1, 0, 0, 0, 10'd4,  32'h0,         32'h0};
    tbl[3]  = '{1, T_IDLE, 0, 3'b010, 32'h0,  32'h0,         0, 0, 0, 1, 10'd4,  32'h0,         32'h0};
    tbl[4]  = '{1, T_NSEQ, 1, 3'b010, 32'h1C, 32'h0,         1, 0, 0, 0, 10'd4,  32'h0,         32'hDEADBEEF};
    tbl[5]  = '{1, T_NSEQ, 0, 3'b010, 32'h1C, 32'h12345678,  1, 0, 1, 0, 10'd7,  32'h12345678,  32'h0};
    tbl[6]  = '{1, T_IDLE, 0, 3'b010, 32'h0,  32'h0,         0, 0, 0, 1, 10'd7,  32'h0,         32'h0};
    tbl[7]  = '{1, T_NSEQ, 1, 3'b010, 32'h20, 32'h0,         1, 0, 0, 0, 10'd7,  32'h0,         32'h12345678};
    tbl[8]  = '{1, T_BUSY, 1, 3'b010, 32'h24, 32'hA0A0A0A0,  1, 0, 1, 0, 10'd8,  32'hA0A0A0A0,  32'h0};
    tbl[9]  = '{1, T_SEQ,  1, 3'b010, 32'h24, 32'h0,         1, 0, 0, 0, 10'd8,  32'h0,         32'h0};
    tbl[10] = '{0, T_NSEQ, 1, 3'b010, 32'h28, 32'hA1A1A1A1,  1, 0, 1, 0, 10'd9,  32'hA1A1A1A1,  32'h0};
    tbl[11] = '{1, T_SEQ,  1, 3'b010, 32'h28, 32'h0,         1, 0, 0, 0, 10'd9,  32'h0,         32'h0};
    tbl[12] = '{1, T_IDLE, 0, 3'b010, 32'h0,  32'hA2A2A2A2,  1, 0, 1, 0, 10'd10, 32'hA2A2A2A2,  32'h0};
    tbl[13] = '{1, T_NSEQ, 0, 3'b010, 32'h24, 32'h0,         1, 0, 0, 0, 10'd10, 32'h0,         32'h0};
    tbl[14] = '{1, T_IDLE, 0, 3'b010, 32'h0,  32'h0,         0, 0, 0, 1, 10'd9,  32'h0,         32'h0};
    tbl[15] = '{1, T_IDLE, 0, 3'b010, 32'h0,  32'h0,         1, 0, 0, 0, 10'd9,  32'h0,         32'hA1A1A1A1};

    hreset = 1'b1;
    drive(1'b0, T_IDLE, 1'b0, 3'b010, 32'h0, 32'h0);
    step();
    #3 check("reset_state", mk(1, 0, 0, 0, 10'd0, 32'h0, 32'h0), ALL);
    step();
    hreset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].sel, tbl[i].trans, tbl[i].write, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      #3 check($sformatf("row%0d", i),
               mk(tbl[i].e_rdy, tbl[i].e_resp, tbl[i].e_wr, tbl[i].e_rd,
                  tbl[i].e_idx, tbl[i].e_wdata, tbl[i].e_rdata), ALL);
      step();
    end

    illegal("misaligned_rd", 1'b0, 3'b010, 32'h12);
    illegal("byte_wr",       1'b1, 3'b000, 32'h40);
    illegal("oob_wr",        1'b1, 3'b010, 32'h1000);
    illegal("oob_rd",        1'b0, 3'b010, 32'h1000);

    // Writes above must not have disturbed idx 0 or idx 16; read idx 4 back to confirm it survived.
    drive(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h10, 32'h0);
    step();
    drive(1'b1, T_IDLE, 1'b0, 3'b010, 32'h0, 32'h0);
    step();
    #3 check("readback_idx4", mk(1, 0, 0, 0, 10'd4, 32'h0, 32'hDEADBEEF), ALL);

    // Reset asserted in the middle of a read wait state.
    drive(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h1C, 32'h0);
    step();
    drive(1'b1, T_IDLE, 1'b0, 3'b010, 32'h0, 32'h0);
    #2 check("rd_wait_before_reset", mk(0, 0, 0, 1, 10'd7, 32'h0, 32'h0), ALL);
    hreset = 1'b1;
    #1 check("reset_mid_rd_wait", mk(1, 0, 0, 0, 10'd0, 32'h0, 32'h0), ALL);
    step();
    hreset = 1'b0;
    step();
    #3 check("idle_after_reset", mk(1, 0, 0, 0, 10'd0, 32'h0, 32'h0), ALL);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary, required completion");
    $fatal(1);
  end

endmodule
